simram_arbiter: RTL and testbench
=================================

Name: simram_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the single-port 256x16 register RAM (8-bit address, 16-bit data, clock-enable, write-enable).
- Port A (host/SPI side) and port B (fabric side) each get a request/acknowledge interface. The block picks one winner round-robin, drives one RAM access, waits out read latency, then returns data with a single-cycle acknowledge.

Parameters:
- AW, 8, address width
- DW, 16, data width
- RD_LAT, 1, RAM read latency in cycles after the issue cycle (legal 1..7)

Ports:
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- a_req_i  in  1  port A request; held until a_ack_o
- a_we_i  in  1  port A write (1) / read (0); stable while a_req_i
- a_addr_i  in  AW  port A address; stable while a_req_i
- a_wdata_i  in  DW  port A write data; stable while a_req_i
- a_ack_o  out  1  port A one-cycle completion pulse
- a_rdata_o  out  DW  port A read data; valid with a_ack_o on reads, held afterwards
- b_req_i, b_we_i, b_addr_i, b_wdata_i, b_ack_o, b_rdata_o  same as port A, for port B
- ram_addr_o  out  AW  RAM address (registered)
- ram_wr_data_o  out  DW  RAM write data (registered)
- ram_wr_en_o  out  1  RAM write enable
- ram_clk_en_o  out  1  RAM clock enable
- ram_rd_data_i  in  DW  RAM read data
- busy_o  out  1  high in any state except IDLE

Behaviour:
- Reset (synchronous, on clock while reset=1):
  - State=IDLE; all outputs 0, including both rdata registers.
  - last_grant=B, so A wins the first contention.
  - Reset mid-transaction aborts it: no ack is issued and no RAM enable is asserted on the following cycle.
- State machine, one-hot: IDLE, ISSUE, WAIT, DONE.
  - IDLE: sample requests.
    - If exactly one req is high, grant it.
    - If both are high, grant the port that is not last_grant.
    - On a grant: latch we/addr/wdata into the ram_* registers, record the grant, update last_grant, go to ISSUE.
    - If no req is high, stay in IDLE.
  - ISSUE: ram_clk_en_o=1; ram_wr_en_o=latched we.
    - Write: go to DONE.
    - Read: load lat_cnt=RD_LAT-1 and go to WAIT.
  - WAIT (reads only): ram_clk_en_o=1, ram_wr_en_o=0.
    - When lat_cnt=0: capture ram_rd_data_i into the granted port's rdata register and go to DONE.
    - Otherwise decrement lat_cnt.
  - DONE: pulse the granted port's ack for exactly 1 cycle; go to IDLE.
- Latency, measured from the IDLE cycle in which req is sampled (cycle 0):
  - Write: RAM write in cycle 1, ack in cycle 2.
  - Read: ack in cycle 2+RD_LAT.
- RAM outputs:
  - ram_clk_en_o and ram_wr_en_o are 0 in IDLE and DONE.
  - ram_addr_o and ram_wr_data_o hold their last latched values when not granted.
- Handshake:
  - Requesters must not change the command while req is high.
  - req may stay high across ack to issue a back-to-back transaction. That request is re-arbitrated in IDLE on the cycle after ack, so a pending request on the other port wins it.
  - A request that drops before ack is a protocol violation. The transaction still completes; its ack goes to the port regardless.
- The non-granted port's rdata is never modified.
- Minimum spacing between successive transactions is 3 cycles (write) or 3+RD_LAT cycles (read).
- lat_cnt is 3 bits. RD_LAT outside 1..7 is flagged by a simulation-only assertion.

Decomposition:
- Shared package:
  - state encoding indices (IDLE, ISSUE, WAIT, DONE)
  - grant encoding (GNT_A=0, GNT_B=1)
  - default AW, DW, RD_LAT
- The round-robin selector is a natural sub-module: simram_rr_sel, 2 requests in, last_grant in, grant + valid out, purely combinational.
- The FSM, latency counter and datapath registers stay in simram_arbiter.

Test Plan:
- A write addr 0x10 data 0x1234, then A read 0x10 (RD_LAT=1) -> write ack at cycle 2; read ack at cycle 3 with a_rdata_o=0x1234; ram_wr_en_o high only in the write's ISSUE cycle.
- A and B both request in the same cycle after reset (A write 0x20=0xBEEF, B read 0x20) -> A granted first; B ack follows with b_rdata_o=0xBEEF; a_rdata_o unchanged.
- A holds req for 3 back-to-back reads while B requests once during A's first transaction -> order A, B, A, A; each ack is a single-cycle pulse.
- RD_LAT=3, B read of 0x05 preloaded 0x00A5 -> b_ack_o at cycle 5; ram_clk_en_o high for cycles 1-4; b_rdata_o=0x00A5.
- reset asserted during WAIT of an A read -> next cycle state IDLE, busy_o=0, no a_ack_o, ram enables 0, rdata registers 0; a subsequent contended request grants A.
- B write 0xFF=0xFFFF, then B read 0xFF, with A idle throughout -> a_ack_o never asserted; b_rdata_o=0xFFFF; address wrap boundary handled with no truncation.

Source files
------------

// File: rtl/simram_arbiter_pkg.sv
// Shared encodings and default widths for the simram request arbiter.
package simram_arbiter_pkg;

    localparam int AW_DEF     = 8;
    localparam int DW_DEF     = 16;
    localparam int RD_LAT_DEF = 1;

    localparam int ST_IDLE  = 0;
    localparam int ST_ISSUE = 1;
    localparam int ST_WAIT  = 2;
    localparam int ST_DONE  = 3;

    typedef enum logic [3:0] {
        S_IDLE  = 4'(1 << ST_IDLE),
        S_ISSUE = 4'(1 << ST_ISSUE),
        S_WAIT  = 4'(1 << ST_WAIT),
        S_DONE  = 4'(1 << ST_DONE)
    } state_e;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } gnt_e;

endpackage

// File: rtl/simram_rr_sel.sv
// Two-way round-robin pick; on contention the port that did not win last time goes.
module simram_rr_sel
    import simram_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  gnt_e       last_grant,
    output gnt_e       grant,
    output logic       valid
);

    always_comb begin
        valid = |req;
        grant = GNT_A;
        if (&req)
            grant = (last_grant == GNT_A) ? GNT_B : GNT_A;
        else if (req[1])
            grant = GNT_B;
    end

endmodule

// File: rtl/simram_arbiter.sv
// Arbitrates ports A/B onto one single-port RAM: grant, issue, wait out read latency, ack.
module simram_arbiter
    import simram_arbiter_pkg::*;
#(
    parameter int AW     = AW_DEF,
    parameter int DW     = DW_DEF,
    parameter int RD_LAT = RD_LAT_DEF
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          a_req_i,
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_wdata_i,
    output logic          a_ack_o,
    output logic [DW-1:0] a_rdata_o,
    input  logic          b_req_i,
    input  logic          b_we_i,
    input  logic [AW-1:0] b_addr_i,
    input  logic [DW-1:0] b_wdata_i,
    output logic          b_ack_o,
    output logic [DW-1:0] b_rdata_o,
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wr_data_o,
    output logic          ram_wr_en_o,
    output logic          ram_clk_en_o,
    input  logic [DW-1:0] ram_rd_data_i,
    output logic          busy_o
);

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    state_e        state_q, state_d;
    gnt_e          gnt_q, last_q, sel_gnt;
    logic          sel_vld;
    logic          we_q;
    logic [2:0]    lat_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q, a_rdata_q, b_rdata_q;

    simram_rr_sel u_sel (
        .req        ({b_req_i, a_req_i}),
        .last_grant (last_q),
        .grant      (sel_gnt),
        .valid      (sel_vld)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (sel_vld) state_d = S_ISSUE;
            S_ISSUE: state_d = we_q ? S_DONE : S_WAIT;
            S_WAIT:  if (lat_q == 3'd0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // RAM stays enabled through WAIT so a pipelined read keeps advancing.
    always_comb begin
        ram_clk_en_o = (state_q == S_ISSUE) || (state_q == S_WAIT);
        ram_wr_en_o  = (state_q == S_ISSUE) && we_q;
        busy_o       = (state_q != S_IDLE);
        a_ack_o      = (state_q == S_DONE) && (gnt_q == GNT_A);
        b_ack_o      = (state_q == S_DONE) && (gnt_q == GNT_B);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_IDLE;
            gnt_q     <= GNT_A;
            last_q    <= GNT_B;
            we_q      <= 1'b0;
            lat_q     <= 3'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (sel_vld) begin
                        gnt_q   <= sel_gnt;
                        last_q  <= sel_gnt;
                        we_q    <= (sel_gnt == GNT_A) ? a_we_i    : b_we_i;
                        addr_q  <= (sel_gnt == GNT_A) ? a_addr_i  : b_addr_i;
                        wdata_q <= (sel_gnt == GNT_A) ? a_wdata_i : b_wdata_i;
                    end
                end
                S_ISSUE: lat_q <= LAT_LOAD;
                S_WAIT: begin
                    if (lat_q == 3'd0) begin
                        if (gnt_q == GNT_A) a_rdata_q <= ram_rd_data_i;
                        else                b_rdata_q <= ram_rd_data_i;
                    end else begin
                        lat_q <= lat_q - 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ram_addr_o    = addr_q;
    assign ram_wr_data_o = wdata_q;
    assign a_rdata_o     = a_rdata_q;
    assign b_rdata_o     = b_rdata_q;

`ifndef SYNTHESIS
    always_ff @(posedge clock)
        assert (RD_LAT >= 1 && RD_LAT <= 7)
        else $error("simram_arbiter: RD_LAT=%0d outside 1..7", RD_LAT);
`endif

endmodule

// File: tb/tb_simram_arbiter.sv
// Bench for simram_arbiter: RD_LAT=1 instance scoreboarded, RD_LAT=3 instance hand-checked.
module tb_simram_arbiter;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    logic        a_req = 0, a_we = 0, b_req = 0, b_we = 0;
    logic [7:0]  a_addr = 0, b_addr = 0;
    logic [15:0] a_wdata = 0, b_wdata = 0;

    logic        a_ack1, b_ack1, busy1, ram_we1, ram_ce1;
    logic [15:0] a_rd1, b_rd1, ram_wd1, ram_rd1;
    logic [7:0]  ram_addr1;
    logic        a_ack3, b_ack3, busy3, ram_we3, ram_ce3;
    logic [15:0] a_rd3, b_rd3, ram_wd3, ram_rd3;
    logic [7:0]  ram_addr3;

    simram_arbiter #(.AW(8), .DW(16), .RD_LAT(1)) dut1 (
        .clock(clock), .reset(reset),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ack_o(a_ack1), .a_rdata_o(a_rd1),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ack_o(b_ack1), .b_rdata_o(b_rd1),
        .ram_addr_o(ram_addr1), .ram_wr_data_o(ram_wd1), .ram_wr_en_o(ram_we1),
        .ram_clk_en_o(ram_ce1), .ram_rd_data_i(ram_rd1), .busy_o(busy1)
    );

    simram_arbiter #(.AW(8), .DW(16), .RD_LAT(3)) dut3 (
        .clock(clock), .reset(reset),
        .a_req_i(a_req), .a_we_i(a_we), .a_addr_i(a_addr), .a_wdata_i(a_wdata),
        .a_ack_o(a_ack3), .a_rdata_o(a_rd3),
        .b_req_i(b_req), .b_we_i(b_we), .b_addr_i(b_addr), .b_wdata_i(b_wdata),
        .b_ack_o(b_ack3), .b_rdata_o(b_rd3),
        .ram_addr_o(ram_addr3), .ram_wr_data_o(ram_wd3), .ram_wr_en_o(ram_we3),
        .ram_clk_en_o(ram_ce3), .ram_rd_data_i(ram_rd3), .busy_o(busy3)
    );

    // RAM models: 1-cycle registered read, and a 3-stage read pipeline advancing on clk_en
    logic [15:0] mem1 [256];
    logic [15:0] mem3 [256];
    logic [15:0] p3_0, p3_1, p3_2;
    logic        pl_en = 0;
    logic [7:0]  pl_addr = 0;
    logic [15:0] pl_data = 0;

    always @(posedge clock)
        if (ram_ce1) begin
            if (ram_we1) mem1[ram_addr1] <= ram_wd1;
            ram_rd1 <= mem1[ram_addr1];
        end

    always @(posedge clock) begin
        if (pl_en) mem3[pl_addr] <= pl_data;
        if (ram_ce3) begin
            if (ram_we3) mem3[ram_addr3] <= ram_wd3;
            p3_0 <= mem3[ram_addr3];
            p3_1 <= p3_0;
            p3_2 <= p3_1;
        end
    end
    assign ram_rd3 = p3_2;

    int vec_cnt = 0;
    int miscmp  = 0;
    int wr_pulses = 0;
    bit mon_en = 1'b1;

    typedef struct {
        bit          port;
        bit          we;
        logic [7:0]  addr;
        logic [15:0] data;
        int          ack_cyc;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        bit          port;
        bit          we;
        logic [7:0]  addr;
        logic [15:0] data;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            miscmp++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic set_port(input bit port, input bit req, input bit we,
                            input logic [7:0] addr, input logic [15:0] data);
        if (port) begin b_req = req; b_we = we; b_addr = addr; b_wdata = data; end
        else      begin a_req = req; a_we = we; a_addr = addr; a_wdata = data; end
    endtask

    task automatic push(input bit port, input bit we, input logic [7:0] addr,
                        input logic [15:0] data, input int ack);
        sbq.push_back('{port, we, addr, data, ack});
    endtask

    task automatic wait_ack(input bit port, input int lim, input bit drop);
        bit found = 1'b0;
        for (int i = 0; i < lim; i++) begin
            @(negedge clock);
            if (port ? b_ack1 : a_ack1) begin found = 1'b1; break; end
        end
        chk(port ? "b_ack_seen" : "a_ack_seen", found, 1);
        if (drop) begin
            if (port) b_req = 1'b0; else a_req = 1'b0;
        end
    endtask

    task automatic do_txn(input vec_t v);
        @(negedge clock);
        set_port(v.port, 1'b1, v.we, v.addr, v.we ? v.data : 16'h0);
        push(v.port, v.we, v.addr, v.data, cyc + (v.we ? 2 : 3));
        wait_ack(v.port, 20, 1'b1);
    endtask

    // Scoreboard monitor for dut1: checks write issue and every ack against the queue
    logic [15:0] mdl_a = 0, mdl_b = 0;
    exp_t me;
    initial forever begin
        @(negedge clock);
        if (reset) begin
            mdl_a = 0;
            mdl_b = 0;
        end else if (mon_en) begin
            if (ram_we1) begin
                wr_pulses++;
                chk("wr_ce", ram_ce1, 1);
                if (sbq.size() == 0) chk("wr_unexpected", 1, 0);
                else begin
                    chk("wr_is_write", sbq[0].we, 1);
                    chk("wr_cycle", cyc, sbq[0].ack_cyc - 1);
                    chk("wr_addr", ram_addr1, sbq[0].addr);
                    chk("wr_data", ram_wd1, sbq[0].data);
                end
            end
            if (a_ack1 || b_ack1) begin
                if (sbq.size() == 0) chk("ack_unexpected", {a_ack1, b_ack1}, 0);
                else begin
                    me = sbq.pop_front();
                    chk("ack_port", {a_ack1, b_ack1}, me.port ? 2'b01 : 2'b10);
                    chk("ack_cycle", cyc, me.ack_cyc);
                    if (!me.we) begin
                        if (me.port) mdl_b = me.data; else mdl_a = me.data;
                    end
                    chk("a_rdata", a_rd1, mdl_a);
                    chk("b_rdata", b_rd1, mdl_b);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        tbl[0] = '{1'b0, 1'b1, 8'h10, 16'h1234};
        tbl[1] = '{1'b0, 1'b0, 8'h10, 16'h1234};
        tbl[2] = '{1'b1, 1'b1, 8'hFF, 16'hFFFF};
        tbl[3] = '{1'b1, 1'b0, 8'hFF, 16'hFFFF};
        tbl[4] = '{1'b0, 1'b1, 8'h00, 16'h0001};
        tbl[5] = '{1'b0, 1'b0, 8'h00, 16'h0001};
        tbl[6] = '{1'b1, 1'b1, 8'h7F, 16'hA5A5};
        tbl[7] = '{1'b1, 1'b0, 8'h7F, 16'hA5A5};

        // reset state
        repeat (3) @(negedge clock);
        chk("rst_busy", busy1, 0);
        chk("rst_acks", {a_ack1, b_ack1}, 0);
        chk("rst_ram_en", {ram_ce1, ram_we1}, 0);
        chk("rst_ram_addr", ram_addr1, 0);
        chk("rst_ram_wdata", ram_wd1, 0);
        chk("rst_a_rdata", a_rd1, 0);
        chk("rst_b_rdata", b_rd1, 0);
        chk("rst_busy3", busy3, 0);
        reset = 1'b0;

        // first contention after reset: A wins
        @(negedge clock);
        n = cyc;
        set_port(0, 1, 1, 8'h20, 16'hBEEF);
        set_port(1, 1, 0, 8'h20, 16'h0);
        push(0, 1, 8'h20, 16'hBEEF, n + 2);
        push(1, 0, 8'h20, 16'hBEEF, n + 6);
        wait_ack(0, 20, 1'b1);
        wait_ack(1, 20, 1'b1);

        // table of single transactions
        for (int i = 0; i < 8; i++) do_txn(tbl[i]);

        // A streams three reads, B slips in once: order A, B, A, A
        @(negedge clock);
        n = cyc;
        set_port(0, 1, 0, 8'h10, 16'h0);
        push(0, 0, 8'h10, 16'h1234, n + 3);
        push(1, 0, 8'hFF, 16'hFFFF, n + 7);
        push(0, 0, 8'h10, 16'h1234, n + 11);
        push(0, 0, 8'h10, 16'h1234, n + 15);
        @(negedge clock);
        set_port(1, 1, 0, 8'hFF, 16'h0);
        wait_ack(0, 20, 1'b0);
        wait_ack(1, 20, 1'b1);
        wait_ack(0, 20, 1'b0);
        wait_ack(0, 20, 1'b1);
        chk("sb_empty", sbq.size(), 0);

        // reset during WAIT of an A read aborts it
        @(negedge clock);
        set_port(0, 1, 0, 8'h10, 16'h0);
        @(negedge clock);
        chk("abort_issue_busy", busy1, 1);
        @(negedge clock);
        chk("abort_wait_ce", ram_ce1, 1);
        reset = 1'b1;
        @(negedge clock);
        chk("abort_busy", busy1, 0);
        chk("abort_ack", a_ack1, 0);
        chk("abort_ram_en", {ram_ce1, ram_we1}, 0);
        chk("abort_a_rdata", a_rd1, 0);
        chk("abort_b_rdata", b_rd1, 0);
        reset = 1'b0;
        set_port(0, 0, 0, 8'h0, 16'h0);

        // contention after reset grants A again
        @(negedge clock);
        n = cyc;
        set_port(0, 1, 1, 8'h30, 16'h1111);
        set_port(1, 1, 1, 8'h31, 16'h2222);
        push(0, 1, 8'h30, 16'h1111, n + 2);
        push(1, 1, 8'h31, 16'h2222, n + 5);
        wait_ack(0, 20, 1'b1);
        wait_ack(1, 20, 1'b1);
        @(negedge clock);
        chk("wr_pulse_count", wr_pulses, 7);
        chk("sb_empty_end", sbq.size(), 0);

        // RD_LAT=3 instance: B read of preloaded 0x05
        mon_en = 1'b0;
        reset = 1'b1;
        set_port(0, 0, 0, 8'h0, 16'h0);
        set_port(1, 0, 0, 8'h0, 16'h0);
        @(negedge clock);
        pl_en = 1'b1; pl_addr = 8'h05; pl_data = 16'h00A5;
        @(negedge clock);
        pl_en = 1'b0;
        reset = 1'b0;
        @(negedge clock);
        set_port(1, 1, 0, 8'h05, 16'h0);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            chk($sformatf("lat3_ce_c%0d", k), ram_ce3, (k <= 4));
            chk($sformatf("lat3_back_c%0d", k), b_ack3, (k == 5));
            chk($sformatf("lat3_aack_c%0d", k), a_ack3, 0);
            if (k == 5) begin
                chk("lat3_b_rdata", b_rd3, 16'h00A5);
                chk("lat3_a_rdata", a_rd3, 0);
                b_req = 1'b0;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp);
        $finish;
    end

endmodule
